// File: rtl/nabp_pkg.sv
// rtl/nabp_pkg.sv - shared NABP constants, channel index type and clog2 helper
package nabp_pkg;

  localparam int kDataLength            = 8;
  localparam int kSinogramAddressLength = 15;
  localparam int kMaxChannels           = 16;
  localparam int kChIdxLength           = 4;

  typedef logic [kChIdxLength-1:0] ch_idx_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/nabp_rr_arbiter.sv
// rtl/nabp_rr_arbiter.sv - round-robin one-hot grant with rotating priority pointer
module nabp_rr_arbiter
  import nabp_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output ch_idx_t           gnt_idx
);

  ch_idx_t pointer;
  logic    found;

  // Two passes: channels at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (advance && !found && req[j] && (ch_idx_t'(j) >= pointer)) begin
        gnt[j]  = 1'b1;
        gnt_idx = ch_idx_t'(j);
        found   = 1'b1;
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (advance && !found && req[j] && (ch_idx_t'(j) < pointer)) begin
        gnt[j]  = 1'b1;
        gnt_idx = ch_idx_t'(j);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      pointer <= '0;
    end else if (clear) begin
      pointer <= '0;
    end else if (found) begin
      pointer <= (gnt_idx == ch_idx_t'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/nabp_sinogram_arbiter.sv
// rtl/nabp_sinogram_arbiter.sv - shares one sinogram RAM read port among NABP channels
module nabp_sinogram_arbiter
  import nabp_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = kSinogramAddressLength,
  parameter int DATA_W  = kDataLength,
  parameter int RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [ADDR_W-1:0]        sg_addr,
  input  logic [DATA_W-1:0]        sg_val,
  output logic                     busy
);

  localparam int IDX_W  = clog2(NUM_CH);
  localparam int STAGES = RAM_LAT + 1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  tag_t              tag_pipe [STAGES];
  ch_idx_t           gnt_idx;
  logic              transfer;
  logic              inflight;
  logic [ADDR_W-1:0] win_addr;

  nabp_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .advance (~flush & ~reset_n),
    .req     (ch_req),
    .gnt     (ch_gnt),
    .gnt_idx (gnt_idx)
  );

  assign transfer = |ch_gnt;
  assign win_addr = ch_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];

  // Tag stage s is visible one cycle after the address plus s; the last stage lines up with sg_val.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      sg_addr   <= '0;
      ch_rvalid <= '0;
      ch_rdata  <= '0;
      for (int s = 0; s < STAGES; s++) tag_pipe[s] <= '0;
    end else begin
      if (transfer) sg_addr <= win_addr;
      ch_rvalid <= '0;
      if (flush) begin
        for (int s = 0; s < STAGES; s++) tag_pipe[s].valid <= 1'b0;
      end else begin
        tag_pipe[0].valid <= transfer;
        tag_pipe[0].idx   <= gnt_idx[IDX_W-1:0];
        for (int s = 1; s < STAGES; s++) tag_pipe[s] <= tag_pipe[s-1];
        if (tag_pipe[STAGES-1].valid) begin
          ch_rvalid[tag_pipe[STAGES-1].idx] <= 1'b1;
          ch_rdata                          <= sg_val;
        end
      end
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int s = 0; s < STAGES; s++) inflight |= tag_pipe[s].valid;
  end

  assign busy = (|ch_req) | inflight | (|ch_rvalid);

endmodule

// File: tb/tb_nabp_sinogram_arbiter.sv
// tb/tb_nabp_sinogram_arbiter.sv - scoreboard bench for the sinogram read arbiter
module tb_nabp_sinogram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         flush_a, flush_b;
  logic [3:0]   req_a, gnt_a, rvalid_a;
  logic [59:0]  addr_a;
  logic [7:0]   req_b, gnt_b, rvalid_b;
  logic [119:0] addr_b;
  logic [7:0]   rdata_a, rdata_b, sg_val_a, sg_val_b;
  logic [14:0]  sg_addr_a, sg_addr_b;
  logic         busy_a, busy_b;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         ch;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [7:0] ram_a;
  logic [7:0] ram_b [3];

  nabp_sinogram_arbiter #(.NUM_CH(4), .ADDR_W(15), .DATA_W(8), .RAM_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .flush(flush_a), .ch_req(req_a), .ch_addr(addr_a),
    .ch_gnt(gnt_a), .ch_rvalid(rvalid_a), .ch_rdata(rdata_a), .sg_addr(sg_addr_a),
    .sg_val(sg_val_a), .busy(busy_a)
  );

  nabp_sinogram_arbiter #(.NUM_CH(8), .ADDR_W(15), .DATA_W(8), .RAM_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(flush_b), .ch_req(req_b), .ch_addr(addr_b),
    .ch_gnt(gnt_b), .ch_rvalid(rvalid_b), .ch_rdata(rdata_b), .sg_addr(sg_addr_b),
    .sg_val(sg_val_b), .busy(busy_b)
  );

  // Behavioural sinogram RAM: data = addr[7:0] ^ 0xA5 after RAM_LAT cycles.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ram_a    <= sg_addr_a[7:0] ^ 8'hA5;
    ram_b[0] <= sg_addr_b[7:0] ^ 8'hA5;
    ram_b[1] <= ram_b[0];
    ram_b[2] <= ram_b[1];
  end
  assign sg_val_a = ram_a;
  assign sg_val_b = ram_b[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic [7:0] rv, input logic [7:0] rd);
    exp_t e;
    if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
      chk(d == 0 ? "a_spurious_rvalid" : "b_spurious_rvalid", {24'h0, rv}, 32'h0);
      return;
    end
    if (d == 0) e = q_a.pop_front();
    else        e = q_b.pop_front();
    chk(d == 0 ? "a_rvalid" : "b_rvalid", {24'h0, rv}, 32'(1 << e.ch));
    chk(d == 0 ? "a_rdata" : "b_rdata", {24'h0, rd}, {24'h0, e.data});
    chk(d == 0 ? "a_latency" : "b_latency", cyc, e.due);
  endtask

  always @(negedge clk) if (!reset_n && rvalid_a !== 4'h0) mon(0, {4'h0, rvalid_a}, rdata_a);
  always @(negedge clk) if (!reset_n && rvalid_b !== 8'h0) mon(1, rvalid_b, rdata_b);

  task automatic step(input int d, input logic fl, input logic [7:0] req,
                      input logic [14:0] base, input int exp_ch, input logic [7:0] exp_data);
    exp_t e;
    @(posedge clk);
    #1;
    if (d == 0) begin
      flush_a = fl;
      req_a   = req[3:0];
      for (int i = 0; i < 4; i++) addr_a[i*15 +: 15] = base + 15'(i);
    end else begin
      flush_b = fl;
      req_b   = req;
      for (int i = 0; i < 8; i++) addr_b[i*15 +: 15] = base + 15'(i);
    end
    @(negedge clk);
    chk(d == 0 ? "a_gnt" : "b_gnt", d == 0 ? {28'h0, gnt_a} : {24'h0, gnt_b},
        exp_ch < 0 ? 32'h0 : 32'(1 << exp_ch));
    if (exp_ch >= 0) begin
      e.ch   = exp_ch;
      e.data = exp_data;
      e.due  = cyc + (d == 0 ? 3 : 5);
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0, 8'h00, 15'h0, -1, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [14:0] base;
    int          ch;
    reset_n = 1'b1;
    flush_a = 1'b0;
    flush_b = 1'b0;
    req_a   = 4'hF;
    req_b   = 8'hFF;
    addr_a  = '0;
    addr_b  = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt_a", {28'h0, gnt_a}, 32'h0);
    chk("rst_gnt_b", {24'h0, gnt_b}, 32'h0);
    chk("rst_rvalid_a", {28'h0, rvalid_a}, 32'h0);
    chk("rst_rdata_a", {24'h0, rdata_a}, 32'h0);
    chk("rst_sg_addr_a", {17'h0, sg_addr_a}, 32'h0);
    chk("rst_sg_addr_b", {17'h0, sg_addr_b}, 32'h0);
    @(posedge clk);
    #1;
    req_a   = 4'h0;
    req_b   = 8'h00;
    reset_n = 1'b0;

    // Single channel 2, back-to-back addresses 0x10..0x13
    step(0, 1'b0, 8'h04, 15'h0E, 2, 8'hB5);
    step(0, 1'b0, 8'h04, 15'h0F, 2, 8'hB4);
    step(0, 1'b0, 8'h04, 15'h10, 2, 8'hB7);
    step(0, 1'b0, 8'h04, 15'h11, 2, 8'hB6);
    step(0, 1'b0, 8'h00, 15'h0, -1, 8'h00);
    chk("sg_addr_hold", {17'h0, sg_addr_a}, 32'h13);
    chk("busy_inflight", {31'h0, busy_a}, 32'h1);
    idle(0, 3);
    chk("busy_idle", {31'h0, busy_a}, 32'h0);

    // Flush beats a simultaneous request and returns the pointer to ch 0
    step(0, 1'b1, 8'h0F, 15'h40, -1, 8'h00);

    // All channels requesting: 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      base = 15'h20 + 15'(k * 4);
      ch   = k % 4;
      step(0, 1'b0, 8'h0F, base, ch, (base[7:0] + 8'(ch)) ^ 8'hA5);
      if (k == 0) chk("sg_addr_after_flush", {17'h0, sg_addr_a}, 32'h13);
    end

    // Ch 1 served, then ch 1 and 3 compete: ch 3 first
    step(0, 1'b0, 8'h02, 15'h50, 1, 8'hF4);
    step(0, 1'b0, 8'h0A, 15'h60, 3, 8'hC6);
    step(0, 1'b0, 8'h0A, 15'h70, 1, 8'hD4);
    idle(0, 4);

    // Flush with two reads in flight: both dropped, next grant is ch 0
    step(0, 1'b0, 8'h04, 15'h80, 2, 8'h00);
    step(0, 1'b0, 8'h04, 15'h88, 2, 8'h00);
    void'(q_a.pop_back());
    void'(q_a.pop_back());
    step(0, 1'b1, 8'h0F, 15'h90, -1, 8'h00);
    step(0, 1'b0, 8'h0F, 15'hA0, 0, 8'h05);
    idle(0, 4);

    // Reset mid-traffic: in-flight reads dropped, pointer back to ch 0
    step(0, 1'b0, 8'h0F, 15'hB0, 1, 8'h00);
    step(0, 1'b0, 8'h0F, 15'hC0, 2, 8'h00);
    void'(q_a.pop_back());
    void'(q_a.pop_back());
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #2;
    chk("midrst_gnt", {28'h0, gnt_a}, 32'h0);
    chk("midrst_rvalid", {28'h0, rvalid_a}, 32'h0);
    chk("midrst_rdata", {24'h0, rdata_a}, 32'h0);
    chk("midrst_sg_addr", {17'h0, sg_addr_a}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    req_a   = 4'h0;
    reset_n = 1'b0;
    idle(0, 5);
    chk("busy_after_rst", {31'h0, busy_a}, 32'h0);
    step(0, 1'b0, 8'h0F, 15'hD0, 0, 8'h75);
    idle(0, 4);

    // NUM_CH=8, RAM_LAT=3: continuous requests, 5-cycle latency, one return per cycle
    for (int k = 0; k < 10; k++) begin
      base = 15'h100 + 15'(k * 8);
      ch   = k % 8;
      step(1, 1'b0, 8'hFF, base, ch, (base[7:0] + 8'(ch)) ^ 8'hA5);
    end
    idle(1, 7);

    for (int i = 0; i < 20 && (q_a.size() + q_b.size()) != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(q_a.size() + q_b.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
